// File: rtl/phase_sequencer_ctrl.sv
// Three-phase sequencer (0 -> 1 -> 2 -> 0) with programmable per-phase dwell,
// sequence counting, pause, restart and single-step control. All outputs registered.
module phase_sequencer_ctrl #(
  parameter int CNT_W  = 8,
  parameter int DWELL0 = 4,
  parameter int DWELL1 = 2,
  parameter int DWELL2 = 3,
  parameter int CYC_W  = 4
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iStart,
  input  logic             iPause,
  input  logic             iRestart,
  input  logic             iStepMode,
  input  logic             iStep,
  input  logic [CYC_W-1:0] iCycles,
  output logic [1:0]       oPhase,
  output logic             oPhaseValid,
  output logic             oPhaseStrobe,
  output logic             oBusy,
  output logic             oDone,
  output logic [CYC_W-1:0] oCycleCount
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;

  // A programmed dwell of 0 behaves like 1, so its reload value is also 0.
  localparam logic [CNT_W-1:0] RELOAD0 = (DWELL0 == 0) ? '0 : CNT_W'(DWELL0 - 1);
  localparam logic [CNT_W-1:0] RELOAD1 = (DWELL1 == 0) ? '0 : CNT_W'(DWELL1 - 1);
  localparam logic [CNT_W-1:0] RELOAD2 = (DWELL2 == 0) ? '0 : CNT_W'(DWELL2 - 1);

  state_t           state_q, state_d;
  logic [1:0]       phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CYC_W-1:0] cycLatched_q, cycLatched_d;
  logic [CYC_W-1:0] cycCount_q, cycCount_d;
  logic             strobe_q, strobe_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             advance;
  logic [CYC_W-1:0] cycNext;

  function automatic logic [CNT_W-1:0] reloadFor(input logic [1:0] p);
    case (p)
      2'd1:    return RELOAD1;
      2'd2:    return RELOAD2;
      default: return RELOAD0;
    endcase
  endfunction

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q      <= IDLE;
      phase_q      <= '0;
      cnt_q        <= '0;
      cycLatched_q <= '0;
      cycCount_q   <= '0;
      strobe_q     <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      cnt_q        <= cnt_d;
      cycLatched_q <= cycLatched_d;
      cycCount_q   <= cycCount_d;
      strobe_q     <= strobe_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    cnt_d        = cnt_q;
    cycLatched_d = cycLatched_q;
    cycCount_d   = cycCount_q;
    strobe_d     = 1'b0;
    done_d       = 1'b0;
    advance      = 1'b0;
    cycNext      = cycCount_q + CYC_W'(1);

    case (state_q)
      IDLE: begin
        if (iStart) begin
          state_d      = RUN;
          phase_d      = 2'd0;
          strobe_d     = 1'b1;
          cnt_d        = RELOAD0;
          cycCount_d   = '0;
          cycLatched_d = iCycles;
        end
      end

      RUN, PAUSED: begin
        if (iRestart) begin
          state_d    = iPause ? PAUSED : RUN;
          phase_d    = 2'd0;
          cnt_d      = RELOAD0;
          cycCount_d = '0;
          strobe_d   = 1'b1;
        end else if (iPause) begin
          state_d = PAUSED;
        end else begin
          // Leaving PAUSED resumes counting in the same edge.
          state_d = RUN;
          if (iStepMode) begin
            advance = iStep;
          end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else begin
            advance = 1'b1;
          end

          if (advance) begin
            if (phase_q == 2'd2) begin
              if ((cycLatched_q != '0) && (cycNext == cycLatched_q)) begin
                state_d    = DONE;
                done_d     = 1'b1;
                phase_d    = 2'd0;
                cycCount_d = cycLatched_q;
              end else begin
                cycCount_d = cycNext;
                phase_d    = 2'd0;
                strobe_d   = 1'b1;
                cnt_d      = RELOAD0;
              end
            end else begin
              phase_d  = phase_q + 2'd1;
              strobe_d = 1'b1;
              cnt_d    = reloadFor(phase_q + 2'd1);
            end
          end
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN) || (state_d == PAUSED);
  end

  assign oPhase       = phase_q;
  assign oPhaseValid  = busy_q;
  assign oBusy        = busy_q;
  assign oPhaseStrobe = strobe_q;
  assign oDone        = done_q;
  assign oCycleCount  = cycCount_q;

endmodule

// File: tb/tb_phase_sequencer_ctrl.sv
// Self-checking bench for phase_sequencer_ctrl: a cycle model pushes expected outputs
// to a scoreboard queue, plus directed checks on the scenarios of interest.
module tb_phase_sequencer_ctrl;

  typedef struct packed {
    logic [1:0] phase;
    logic       valid;
    logic       strobe;
    logic       busy;
    logic       done;
    logic [3:0] count;
  } outs_t;

  logic       iClk = 1'b0;
  logic       iRst_n, iStart, iPause, iRestart, iStepMode, iStep;
  logic [3:0] iCycles;
  logic [1:0] oPhase;
  logic       oPhaseValid, oPhaseStrobe, oBusy, oDone;
  logic [3:0] oCycleCount;

  int    checks = 0;
  int    failures = 0;
  outs_t expQ[$];

  // Reference model state: 0 idle, 1 run, 2 paused, 3 done.
  int mState, mPhase, mCnt, mLatched, mCount;
  bit mStrobe, mDone;

  phase_sequencer_ctrl #(.CNT_W(8), .DWELL0(4), .DWELL1(2), .DWELL2(3), .CYC_W(4)) dut (
    .iClk(iClk), .iRst_n(iRst_n), .iStart(iStart), .iPause(iPause), .iRestart(iRestart),
    .iStepMode(iStepMode), .iStep(iStep), .iCycles(iCycles), .oPhase(oPhase),
    .oPhaseValid(oPhaseValid), .oPhaseStrobe(oPhaseStrobe), .oBusy(oBusy), .oDone(oDone),
    .oCycleCount(oCycleCount)
  );

  always #5 iClk = ~iClk;

  function automatic int dwellLeft(input int p);
    return (p == 0) ? 3 : ((p == 1) ? 1 : 2);
  endfunction

  function automatic outs_t observed();
    outs_t o;
    o.phase  = oPhase;
    o.valid  = oPhaseValid;
    o.strobe = oPhaseStrobe;
    o.busy   = oBusy;
    o.done   = oDone;
    o.count  = oCycleCount;
    return o;
  endfunction

  task automatic modelReset();
    mState = 0; mPhase = 0; mCnt = 0; mLatched = 0; mCount = 0;
    mStrobe = 0; mDone = 0;
    expQ.delete();
  endtask

  task automatic modelEdge();
    bit adv;
    mStrobe = 0;
    mDone   = 0;
    case (mState)
      0: if (iStart) begin
        mState = 1; mPhase = 0; mStrobe = 1; mCnt = 3; mCount = 0; mLatched = int'(iCycles);
      end
      1, 2: begin
        if (iRestart) begin
          mPhase = 0; mCnt = 3; mCount = 0; mStrobe = 1; mState = iPause ? 2 : 1;
        end else if (iPause) begin
          mState = 2;
        end else begin
          mState = 1;
          adv = iStepMode ? iStep : (mCnt == 0);
          if (!iStepMode && mCnt != 0) mCnt--;
          if (adv) begin
            if (mPhase == 2) begin
              if (mLatched != 0 && ((mCount + 1) % 16) == mLatched) begin
                mState = 3; mDone = 1; mPhase = 0; mCount = mLatched;
              end else begin
                mCount = (mCount + 1) % 16; mPhase = 0; mStrobe = 1; mCnt = 3;
              end
            end else begin
              mPhase++; mStrobe = 1; mCnt = dwellLeft(mPhase);
            end
          end
        end
      end
      default: mState = 0;
    endcase
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: predict, push, clock, then pop and compare at posedge+1.
  task automatic applyStimulus();
    outs_t e;
    modelEdge();
    e.phase  = 2'(mPhase);
    e.valid  = (mState == 1 || mState == 2);
    e.strobe = mStrobe;
    e.busy   = (mState == 1 || mState == 2);
    e.done   = mDone;
    e.count  = 4'(mCount);
    expQ.push_back(e);
    @(posedge iClk);
    #1;
    e = expQ.pop_front();
    checkOutput("scoreboard", 32'(observed()), 32'(e));
  endtask

  int    phaseCnt, doneCnt, guard;
  bit    sawWrap15, sawWrap0;
  logic [3:0] prevCount;
  logic [1:0] expPhase2 [10];

  initial begin
    expPhase2 = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd0};
    iRst_n = 1'b0; iStart = 0; iPause = 0; iRestart = 0; iStepMode = 0; iStep = 0; iCycles = 0;
    modelReset();
    repeat (2) @(posedge iClk);
    @(negedge iClk);
    iRst_n = 1'b1;
    checkOutput("reset_outputs", 32'(observed()), 32'd0);
    repeat (3) applyStimulus();
    checkOutput("idle_no_start", 32'(oPhaseValid), 32'd0);

    // Single sequence: phase trace over E0..E9, done at E9.
    $display("[TB] single sequence");
    iCycles = 4'd1; iStart = 1;
    for (int k = 0; k < 10; k++) begin
      applyStimulus();
      iStart = 0;
      checkOutput($sformatf("seq1_phase_E%0d", k), 32'(oPhase), 32'(expPhase2[k]));
      checkOutput($sformatf("seq1_strobe_E%0d", k), 32'(oPhaseStrobe),
                  32'((k == 0 || k == 4 || k == 6) ? 1 : 0));
    end
    checkOutput("seq1_done", 32'(oDone), 32'd1);
    checkOutput("seq1_count", 32'(oCycleCount), 32'd1);
    checkOutput("seq1_busy", 32'(oBusy), 32'd0);
    applyStimulus();
    checkOutput("seq1_done_pulse", 32'(oDone), 32'd0);
    checkOutput("seq1_count_hold", 32'(oCycleCount), 32'd1);

    // Pause for 5 cycles starting at first cycle of phase 1.
    $display("[TB] pause");
    iCycles = 4'd2; iStart = 1;
    applyStimulus();
    iStart = 0;
    repeat (4) applyStimulus();
    checkOutput("pause_phase1_entry", 32'(oPhase), 32'd1);
    phaseCnt = 1;
    iPause = 1;
    for (int k = 0; k < 5; k++) begin
      applyStimulus();
      if (oPhase == 2'd1) phaseCnt++;
      checkOutput("pause_no_strobe", 32'(oPhaseStrobe), 32'd0);
    end
    iPause = 0;
    guard = 0;
    while (oPhase == 2'd1 && guard < 20) begin
      applyStimulus();
      if (oPhase == 2'd1) phaseCnt++;
      guard++;
    end
    checkOutput("pause_phase1_len", 32'(phaseCnt), 32'd7);
    checkOutput("pause_phase2_strobe", 32'(oPhaseStrobe), 32'd1);

    // Restart while paused in phase 2, then release pause immediately.
    $display("[TB] restart");
    iRestart = 1; iPause = 1;
    applyStimulus();
    iRestart = 0; iPause = 0;
    checkOutput("restart_phase", 32'(oPhase), 32'd0);
    checkOutput("restart_strobe", 32'(oPhaseStrobe), 32'd1);
    checkOutput("restart_count", 32'(oCycleCount), 32'd0);
    checkOutput("restart_busy", 32'(oBusy), 32'd1);
    phaseCnt = 1;
    guard = 0;
    while (oPhase == 2'd0 && guard < 20) begin
      applyStimulus();
      if (oPhase == 2'd0) phaseCnt++;
      guard++;
    end
    checkOutput("restart_phase0_len", 32'(phaseCnt), 32'd4);
    doneCnt = 0; guard = 0;
    while (doneCnt == 0 && guard < 60) begin
      applyStimulus();
      if (oDone) doneCnt++;
      guard++;
    end
    checkOutput("restart_done_seen", 32'(doneCnt), 32'd1);
    checkOutput("restart_done_count", 32'(oCycleCount), 32'd2);
    applyStimulus();

    // Step mode, run forever.
    $display("[TB] step mode");
    iCycles = 4'd0; iStepMode = 1; iStart = 1;
    applyStimulus();
    iStart = 0;
    repeat (20) applyStimulus();
    checkOutput("step_hold_phase", 32'(oPhase), 32'd0);
    for (int k = 0; k < 3; k++) begin
      iStep = 1;
      applyStimulus();
      iStep = 0;
      checkOutput($sformatf("step_phase_%0d", k), 32'(oPhase), 32'((k + 1) % 3));
      checkOutput($sformatf("step_strobe_%0d", k), 32'(oPhaseStrobe), 32'd1);
      applyStimulus();
    end
    checkOutput("step_count", 32'(oCycleCount), 32'd1);

    // Free run: 17 sequences, wrap of the cycle counter, start ignored.
    $display("[TB] free run");
    iStepMode = 0;
    doneCnt = 0; sawWrap15 = 0; sawWrap0 = 0;
    prevCount = oCycleCount;
    for (int k = 0; k < 17 * 9 + 4; k++) begin
      iStart = (k >= 40 && k < 44);
      applyStimulus();
      if (oDone) doneCnt++;
      if (prevCount == 4'd15 && oCycleCount == 4'd0) sawWrap15 = 1;
      if (sawWrap15 && prevCount == 4'd0 && oCycleCount == 4'd1) sawWrap0 = 1;
      prevCount = oCycleCount;
    end
    iStart = 0;
    checkOutput("forever_no_done", 32'(doneCnt), 32'd0);
    checkOutput("forever_wrap_15_0", 32'(sawWrap15), 32'd1);
    checkOutput("forever_wrap_0_1", 32'(sawWrap0), 32'd1);
    checkOutput("forever_busy", 32'(oBusy), 32'd1);

    // Asynchronous reset mid-run, observed before any clock edge.
    $display("[TB] async reset");
    #2;
    iRst_n = 1'b0;
    #1;
    checkOutput("async_reset_outputs", 32'(observed()), 32'd0);
    modelReset();
    @(negedge iClk);
    iRst_n = 1'b1;
    repeat (4) applyStimulus();
    checkOutput("post_reset_idle", 32'(oBusy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
